pipe_sched: RTL and testbench

- Central sequencing controller for the 5-stage pipelined CPU: PC, IF/ID, ID/EX, EX/MEM, MEM/WB.
- Replaces ad-hoc hazard wiring with one arbiter for PC/IF/ID write enables, IF/ID flush, ID/EX bubble insertion, multi-cycle data-memory freeze and a halt/drain sequence.
- Maintains cycle, stall and flush performance counters for the bench.

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/pipe_sched_if.sv | 51 +++++
 rtl/sat_counter.sv | 20 ++
 rtl/pipe_sched.sv | 146 ++++++++++++++
 tb/tb_pipe_sched.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
// Holds the FSM state encoding, instruction constants and the load-use test.
package pipe_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RUN      = 3'd1,
    S_MEM_WAIT = 3'd2,
    S_DRAIN    = 3'd3,
    S_HALTED   = 3'd4
  } state_e;

  localparam logic [31:0] NOP_INSN  = 32'h00000013;
  localparam logic [31:0] HALT_INSN = 32'h00000000;

  function automatic logic load_use(
    input logic       memread,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic [4:0] rs2
  );
    return memread && (rd != 5'd0) &&
           ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/pipe_sched_if.sv
// Hazard inputs, pipeline control outputs and perf counters
// of the sequencing controller, bundled for the top-level port.
interface pipe_sched_if #(
  parameter int CNT_W = 32
);
  logic             run_i;
  logic [4:0]       ifid_rs1_i;
  logic [4:0]       ifid_rs2_i;
  logic             idex_memread_i;
  logic [4:0]       idex_rd_i;
  logic             branch_taken_i;
  logic             halt_i;
  logic             dmem_req_i;
  logic             dmem_ready_i;
  logic             pc_write_o;
  logic             ifid_write_o;
  logic             ifid_flush_o;
  logic             idex_bubble_o;
  logic             pipe_en_o;
  logic             halted_o;
  logic             err_o;
  logic [2:0]       state_o;
  logic [CNT_W-1:0] cycle_cnt_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output run_i, ifid_rs1_i, ifid_rs2_i,
    output idex_memread_i, idex_rd_i,
    output branch_taken_i, halt_i,
    output dmem_req_i, dmem_ready_i,
    input  pc_write_o, ifid_write_o,
    input  ifid_flush_o, idex_bubble_o,
    input  pipe_en_o, halted_o, err_o,
    input  state_o, cycle_cnt_o,
    input  stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  run_i, ifid_rs1_i, ifid_rs2_i,
    input  idex_memread_i, idex_rd_i,
    input  branch_taken_i, halt_i,
    input  dmem_req_i, dmem_ready_i,
    output pc_write_o, ifid_write_o,
    output ifid_flush_o, idex_bubble_o,
    output pipe_en_o, halted_o, err_o,
    output state_o, cycle_cnt_o,
    output stall_cnt_o, flush_cnt_o
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// Asynchronous active-low clear.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && !(&count)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_sched.sv
// Central sequencing controller for the 5-stage pipeline: hazard
// arbitration, memory freeze, halt/drain and performance counters.
module pipe_sched
  import pipe_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int DRAIN_CYCLES = 3,
  parameter int MAX_WAIT     = 16
) (
  input  logic         clk_i,
  input  logic         start_i,
  pipe_sched_if.slave  bus
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);
  localparam logic [DW-1:0] DRN_LAST  = DW'(DRAIN_CYCLES - 1);

  state_e        state, state_n;
  logic [WW-1:0] wait_q, wait_n;
  logic [DW-1:0] drain_q, drain_n;
  logic          err_q, err_n;

  logic pc_write, ifid_write, flush;
  logic bubble, pipe_en;
  logic stall_inc, cycle_inc;
  logic lu, mstall;

  assign lu = load_use(bus.idex_memread_i, bus.idex_rd_i,
                       bus.ifid_rs1_i, bus.ifid_rs2_i);
  assign mstall = bus.dmem_req_i && !bus.dmem_ready_i;

  always_comb begin
    pc_write   = 1'b0;
    ifid_write = 1'b0;
    flush      = 1'b0;
    bubble     = 1'b0;
    pipe_en    = 1'b0;
    stall_inc  = 1'b0;
    state_n    = state;
    wait_n     = wait_q;
    drain_n    = drain_q;
    err_n      = err_q;
    unique case (state)
      S_IDLE: begin
        if (bus.run_i) state_n = S_RUN;
      end
      S_RUN, S_MEM_WAIT: begin
        if ((state == S_RUN && mstall) ||
            (state == S_MEM_WAIT && !bus.dmem_ready_i)) begin
          stall_inc = 1'b1;
          if (state == S_RUN) begin
            wait_n  = WW'(1);
            state_n = S_MEM_WAIT;
          end else if (wait_q >= WAIT_LAST) begin
            err_n   = 1'b1;
            state_n = S_HALTED;
          end else begin
            wait_n = wait_q + 1'b1;
          end
        end else begin
          // ready cycle out of MEM_WAIT is an ordinary RUN cycle
          state_n    = S_RUN;
          wait_n     = '0;
          pc_write   = 1'b1;
          ifid_write = 1'b1;
          pipe_en    = 1'b1;
          if (bus.halt_i) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            state_n    = S_DRAIN;
            drain_n    = '0;
          end else if (lu) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            bubble     = 1'b1;
            stall_inc  = 1'b1;
          end else if (bus.branch_taken_i) begin
            flush = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (!mstall) begin
          bubble  = 1'b1;
          pipe_en = 1'b1;
          if (drain_q >= DRN_LAST) state_n = S_HALTED;
          else drain_n = drain_q + 1'b1;
        end
      end
      S_HALTED: begin
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      state   <= S_IDLE;
      wait_q  <= '0;
      drain_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      wait_q  <= wait_n;
      drain_q <= drain_n;
      err_q   <= err_n;
    end
  end

  assign cycle_inc = (state == S_RUN) ||
                     (state == S_MEM_WAIT) ||
                     (state == S_DRAIN);

  sat_counter #(.W(CNT_W)) u_cycle (
    .clk   (clk_i),
    .rst_n (start_i),
    .inc   (cycle_inc),
    .count (bus.cycle_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_stall (
    .clk   (clk_i),
    .rst_n (start_i),
    .inc   (stall_inc),
    .count (bus.stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush (
    .clk   (clk_i),
    .rst_n (start_i),
    .inc   (flush),
    .count (bus.flush_cnt_o)
  );

  assign bus.pc_write_o    = pc_write;
  assign bus.ifid_write_o  = ifid_write;
  assign bus.ifid_flush_o  = flush;
  assign bus.idex_bubble_o = bubble;
  assign bus.pipe_en_o     = pipe_en;
  assign bus.halted_o      = (state == S_HALTED);
  assign bus.err_o         = err_q;
  assign bus.state_o       = state;

endmodule

// File: tb/tb_pipe_sched.sv
// Bench for pipe_sched: directed hazard scenarios plus random
// traffic checked against a behavioural sequencing model.
module tb_pipe_sched;

  localparam int CW   = 8;
  localparam int MAXV = (1 << CW) - 1;

  logic clk = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  pipe_sched_if #(.CNT_W(CW)) bus ();

  pipe_sched #(
    .CNT_W        (CW),
    .DRAIN_CYCLES (3),
    .MAX_WAIT     (16)
  ) dut (
    .clk_i   (clk),
    .start_i (start),
    .bus     (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // model: phase 0 idle,1 run,2 mem wait,3 drain,4 halted
  int m_st, m_cyc, m_stl, m_fl;
  int m_streak, m_left;
  bit m_err;
  logic [4:0] obs_ctrl;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(int x);
    return (x >= MAXV) ? MAXV : x + 1;
  endfunction

  function automatic bit m_lu();
    return bus.idex_memread_i && bus.idex_rd_i != 0 &&
      (bus.idex_rd_i == bus.ifid_rs1_i ||
       bus.idex_rd_i == bus.ifid_rs2_i);
  endfunction

  function automatic bit m_frz();
    bit ms;
    ms = bus.dmem_req_i && !bus.dmem_ready_i;
    if (m_st == 2) return !bus.dmem_ready_i;
    if (m_st == 1 || m_st == 3) return ms;
    return 0;
  endfunction

  // {pc_write, ifid_write, flush, bubble, pipe_en}
  function automatic logic [4:0] m_ctrl();
    if (m_st == 0 || m_st == 4 || m_frz()) return 5'b00000;
    if (m_st == 3) return 5'b00011;
    if (bus.halt_i) return 5'b00001;
    if (m_lu()) return 5'b00011;
    if (bus.branch_taken_i) return 5'b11101;
    return 5'b11001;
  endfunction

  task automatic m_advance();
    bit frz;
    frz = m_frz();
    case (m_st)
      0: if (bus.run_i) m_st = 1;
      1, 2: begin
        m_cyc = sat(m_cyc);
        if (frz) begin
          m_stl = sat(m_stl);
          m_streak++;
          if (m_st == 1) begin
            m_streak = 1;
            m_st = 2;
          end else if (m_streak >= 16) begin
            m_err = 1;
            m_st = 4;
          end
        end else begin
          m_streak = 0;
          m_st = 1;
          if (bus.halt_i) begin
            m_st = 3;
            m_left = 3;
          end else if (m_lu()) m_stl = sat(m_stl);
          else if (bus.branch_taken_i) m_fl = sat(m_fl);
        end
      end
      3: begin
        m_cyc = sat(m_cyc);
        if (!frz) begin
          m_left--;
          if (m_left == 0) m_st = 4;
        end
      end
      default: ;
    endcase
  endtask

  task automatic m_reset();
    m_st = 0; m_cyc = 0; m_stl = 0; m_fl = 0;
    m_streak = 0; m_left = 0; m_err = 0;
  endtask

  task automatic clr_in();
    bus.run_i = 0;
    bus.ifid_rs1_i = 0;
    bus.ifid_rs2_i = 0;
    bus.idex_memread_i = 0;
    bus.idex_rd_i = 0;
    bus.branch_taken_i = 0;
    bus.halt_i = 0;
    bus.dmem_req_i = 0;
    bus.dmem_ready_i = 0;
  endtask

  task automatic cyc_check();
    logic [4:0] e;
    @(negedge clk);
    e = m_ctrl();
    obs_ctrl = {bus.pc_write_o, bus.ifid_write_o,
                bus.ifid_flush_o, bus.idex_bubble_o,
                bus.pipe_en_o};
    chk("ctrl", 32'(obs_ctrl), 32'(e));
    chk("state", 32'(bus.state_o), m_st);
    chk("halted", 32'(bus.halted_o), 32'(m_st == 4));
    chk("err", 32'(bus.err_o), 32'(m_err));
    chk("cycle_cnt", 32'(bus.cycle_cnt_o), m_cyc);
    chk("stall_cnt", 32'(bus.stall_cnt_o), m_stl);
    chk("flush_cnt", 32'(bus.flush_cnt_o), m_fl);
    m_advance();
    @(posedge clk);
    #1;
  endtask

  // async reset: outputs must clear before the next edge
  task automatic do_reset();
    clr_in();
    start = 1'b0;
    #2;
    chk("rst_state", 32'(bus.state_o), 0);
    chk("rst_cycle", 32'(bus.cycle_cnt_o), 0);
    chk("rst_stall", 32'(bus.stall_cnt_o), 0);
    chk("rst_flush", 32'(bus.flush_cnt_o), 0);
    chk("rst_err", 32'(bus.err_o), 0);
    m_reset();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic go_run();
    do_reset();
    bus.run_i = 1;
    cyc_check();
    chk("idle_out", 32'(obs_ctrl), 0);
  endtask

  bit lowrdy;

  initial begin
    clr_in();
    m_reset();
    #1;
    chk("por_state", 32'(bus.state_o), 0);

    // plain run
    go_run();
    for (int i = 0; i < 10; i++) cyc_check();
    chk("run_pc", 32'(obs_ctrl[4]), 1);
    chk("run10_cyc", 32'(bus.cycle_cnt_o), 10);
    chk("run10_stl", 32'(bus.stall_cnt_o), 0);
    chk("run10_fl", 32'(bus.flush_cnt_o), 0);

    // load-use, then rd=0
    bus.idex_memread_i = 1;
    bus.idex_rd_i = 5;
    bus.ifid_rs1_i = 5;
    cyc_check();
    chk("lu_pc", 32'(obs_ctrl[4]), 0);
    chk("lu_bub", 32'(obs_ctrl[1]), 1);
    chk("lu_stl", 32'(bus.stall_cnt_o), 1);
    bus.idex_rd_i = 0;
    bus.ifid_rs1_i = 0;
    cyc_check();
    chk("rd0_pc", 32'(obs_ctrl[4]), 1);
    chk("rd0_stl", 32'(bus.stall_cnt_o), 1);

    // branch alone, then branch with load-use
    bus.idex_memread_i = 0;
    bus.branch_taken_i = 1;
    cyc_check();
    chk("br_flush", 32'(obs_ctrl[2]), 1);
    chk("br_fl", 32'(bus.flush_cnt_o), 1);
    bus.idex_memread_i = 1;
    bus.idex_rd_i = 7;
    bus.ifid_rs2_i = 7;
    cyc_check();
    chk("brlu_flush", 32'(obs_ctrl[2]), 0);
    chk("brlu_stl", 32'(bus.stall_cnt_o), 2);
    chk("brlu_fl", 32'(bus.flush_cnt_o), 1);
    clr_in();
    bus.run_i = 1;

    // 4-cycle memory stall
    bus.dmem_req_i = 1;
    for (int i = 0; i < 4; i++) begin
      cyc_check();
      chk("mw_frz", 32'(obs_ctrl), 0);
    end
    chk("mw_state", 32'(bus.state_o), 2);
    chk("mw_stl", 32'(bus.stall_cnt_o), 6);
    bus.dmem_ready_i = 1;
    cyc_check();
    chk("mw_resume", 32'(obs_ctrl[4]), 1);
    chk("mw_back", 32'(bus.state_o), 1);

    // 15 frozen cycles is still legal, 16 times out
    go_run();
    bus.dmem_req_i = 1;
    for (int i = 0; i < 15; i++) cyc_check();
    bus.dmem_ready_i = 1;
    cyc_check();
    chk("w15_err", 32'(bus.err_o), 0);
    go_run();
    bus.dmem_req_i = 1;
    for (int i = 0; i < 16; i++) cyc_check();
    chk("w16_err", 32'(bus.err_o), 1);
    chk("w16_st", 32'(bus.state_o), 4);
    cyc_check();

    // halt and drain
    go_run();
    bus.halt_i = 1;
    cyc_check();
    bus.halt_i = 0;
    for (int i = 0; i < 3; i++) begin
      cyc_check();
      chk("drn_ctrl", 32'(obs_ctrl), 32'(5'b00011));
    end
    chk("drn_halted", 32'(bus.halted_o), 1);
    for (int i = 0; i < 3; i++) cyc_check();
    chk("drn_cyc", 32'(bus.cycle_cnt_o), 4);

    // reset landing in the middle of DRAIN
    go_run();
    bus.halt_i = 1;
    cyc_check();
    bus.halt_i = 0;
    cyc_check();
    do_reset();

    // saturation of the cycle counter
    go_run();
    for (int i = 0; i < 300; i++) cyc_check();
    chk("sat_cyc", 32'(bus.cycle_cnt_o), MAXV);

    // random traffic
    do_reset();
    lowrdy = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) lowrdy = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 99) == 0) do_reset();
      bus.run_i = ($urandom_range(0, 9) != 0);
      bus.ifid_rs1_i = 5'($urandom_range(0, 3));
      bus.ifid_rs2_i = 5'($urandom_range(0, 3));
      bus.idex_rd_i = 5'($urandom_range(0, 3));
      bus.idex_memread_i = ($urandom_range(0, 2) == 0);
      bus.branch_taken_i = ($urandom_range(0, 3) == 0);
      bus.halt_i = ($urandom_range(0, 39) == 0);
      bus.dmem_req_i = ($urandom_range(0, 1) == 0);
      bus.dmem_ready_i = lowrdy ?
        ($urandom_range(0, 19) == 0) :
        ($urandom_range(0, 2) != 0);
      cyc_check();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
